sys_array_tiler: RTL

Tile sequencer for the weight-stationary systolic array: splits a runtime-sized product O[M×N] = W[M×K] · B[K×N] into array-sized tiles and drives per-tile fetch, weight-load, column-stream and output-capture control. It is the parametrised successor of the fixed-size fetcher. Dimensions are run-time ports, tiling is a deterministic loop nest, and data movement uses explicit handshakes. It sits between the host-side buffers/loader and `sys_array_basic`, and carries no data path of its own.

---
 rtl/sys_array_pkg.sv | 31 +++
 rtl/sys_array_tiler_if.sv | 41 ++++
 rtl/sys_array_tile_cnt.sv | 43 ++++
 rtl/sys_array_tiler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Types shared by the tile sequencer, the loader and the accumulator.
package sys_array_pkg;

   localparam int DESC_DIM_WIDTH = 16;
   localparam int DESC_LEN_WIDTH = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } tiler_state_t;

   typedef struct packed {
      logic [DESC_DIM_WIDTH-1:0] m0;
      logic [DESC_DIM_WIDTH-1:0] k0;
      logic [DESC_DIM_WIDTH-1:0] n0;
      logic [DESC_LEN_WIDTH-1:0] m_len;
      logic [DESC_LEN_WIDTH-1:0] k_len;
      logic [DESC_LEN_WIDTH-1:0] n_len;
      logic                      acc_first;
      logic                      acc_last;
   } tile_desc_t;

   function automatic int unsigned clamp_len(input int unsigned tile, input int unsigned remain);
      return (remain < tile) ? remain : tile;
   endfunction

endpackage

// File: rtl/sys_array_tiler_if.sv
// Tile descriptor / fetch handshake and array stream-capture control bundle.
interface sys_array_tiler_if #(
   parameter int DIM_WIDTH = 16,
   parameter int TILE_W    = 4,
   parameter int TILE_L    = 4,
   parameter int TILE_A_L  = 4
);
   localparam int M_LEN_W = $clog2(TILE_W + 1);
   localparam int K_LEN_W = $clog2(TILE_L + 1);
   localparam int N_LEN_W = $clog2(TILE_A_L + 1);
   localparam int IDX_W   = (TILE_A_L > 1) ? $clog2(TILE_A_L) : 1;

   logic                 fetch_req;
   logic                 fetch_ack;
   logic [DIM_WIDTH-1:0] tile_m0;
   logic [DIM_WIDTH-1:0] tile_k0;
   logic [DIM_WIDTH-1:0] tile_n0;
   logic [M_LEN_W-1:0]   tile_m_len;
   logic [K_LEN_W-1:0]   tile_k_len;
   logic [N_LEN_W-1:0]   tile_n_len;
   logic                 acc_first;
   logic                 acc_last;
   logic                 w_load;
   logic                 b_col_valid;
   logic [IDX_W-1:0]     b_col_idx;
   logic                 o_valid;
   logic [IDX_W-1:0]     o_col_idx;

   modport master (
      output fetch_req, tile_m0, tile_k0, tile_n0, tile_m_len, tile_k_len, tile_n_len,
             acc_first, acc_last, w_load, b_col_valid, b_col_idx, o_valid, o_col_idx,
      input  fetch_ack
   );

   modport slave (
      input  fetch_req, tile_m0, tile_k0, tile_n0, tile_m_len, tile_k_len, tile_n_len,
             acc_first, acc_last, w_load, b_col_valid, b_col_idx, o_valid, o_col_idx,
      output fetch_ack
   );

endinterface

// File: rtl/sys_array_tile_cnt.sv
// One loop level of the tile nest: latched dimension, origin, clamped extent and wrap flag.
module sys_array_tile_cnt
   import sys_array_pkg::*;
#(
   parameter int TILE      = 4,
   parameter int DIM_WIDTH = 16,
   parameter int LEN_WIDTH = $clog2(TILE + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 load,
   input  logic [DIM_WIDTH-1:0] dim_in,
   input  logic                 adv_in,
   output logic [DIM_WIDTH-1:0] origin,
   output logic [LEN_WIDTH-1:0] len,
   output logic                 wrap
);
   logic [DIM_WIDTH-1:0] dim_q;
   logic [DIM_WIDTH:0]   next_origin;
   logic [DIM_WIDTH:0]   remain;

   // One extra bit keeps origin+TILE from wrapping when dim sits near the top of the range.
   assign next_origin = {1'b0, origin} + (DIM_WIDTH + 1)'(TILE);
   assign remain      = {1'b0, dim_q} - {1'b0, origin};
   assign wrap        = (next_origin >= {1'b0, dim_q});
   assign len         = LEN_WIDTH'(clamp_len(32'(TILE), 32'(remain)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dim_q  <= '0;
         origin <= '0;
      end else if (en) begin
         if (load) begin
            dim_q  <= dim_in;
            origin <= '0;
         end else if (adv_in) begin
            origin <= wrap ? '0 : next_origin[DIM_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/sys_array_tiler.sv
// Tile sequencer for the weight-stationary systolic array (m outer, n middle, k inner).
// Optional perf counters are built when SYS_ARRAY_TILER_PERF_EN is defined.
module sys_array_tiler
   import sys_array_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_W     = 4,
   parameter int TILE_L     = 4,
   parameter int TILE_A_L   = 4,
   parameter int DIM_WIDTH  = 16,
   parameter int ARRAY_LAT  = TILE_W + TILE_L
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 start,
   input  logic [DIM_WIDTH-1:0] dim_m,
   input  logic [DIM_WIDTH-1:0] dim_k,
   input  logic [DIM_WIDTH-1:0] dim_n,
   output logic                 busy,
   output logic                 done,
`ifdef SYS_ARRAY_TILER_PERF_EN
   output logic [31:0]          perf_cycles,
   output logic [31:0]          perf_stall,
`endif
   sys_array_tiler_if.master    bus
);
   localparam int M_LEN_W = $clog2(TILE_W + 1);
   localparam int K_LEN_W = $clog2(TILE_L + 1);
   localparam int N_LEN_W = $clog2(TILE_A_L + 1);
   localparam int IDX_W   = (TILE_A_L > 1) ? $clog2(TILE_A_L) : 1;

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_FETCH  = FETCH;
   localparam logic [2:0] S_LOAD   = LOAD;
   localparam logic [2:0] S_STREAM = STREAM;
   localparam logic [2:0] S_DRAIN  = DRAIN;
   localparam logic [2:0] S_DONE   = DONE;

   if (DATA_WIDTH < 1 || ARRAY_LAT < 2) begin : g_cfg_check
      $error("sys_array_tiler: DATA_WIDTH must be >= 1 and ARRAY_LAT >= 2");
   end

   logic [2:0]           state;
   logic [IDX_W-1:0]     col_cnt;
   logic [ARRAY_LAT-1:0] dl_valid;
   logic [IDX_W-1:0]     dl_idx [ARRAY_LAT];

   logic [DIM_WIDTH-1:0] m0, k0, n0;
   logic [M_LEN_W-1:0]   m_len;
   logic [K_LEN_W-1:0]   k_len;
   logic [N_LEN_W-1:0]   n_len;
   logic                 wrap_m, wrap_k, wrap_n;

   logic accept, any_zero, in_tile, last_col, drain_exit, last_tile;
   logic adv_k, adv_n, adv_m;

   assign accept     = (state == S_IDLE) && start;
   assign any_zero   = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
   assign in_tile    = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_STREAM) || (state == S_DRAIN);
   assign last_col   = ((N_LEN_W'(col_cnt) + N_LEN_W'(1)) == n_len);
   assign last_tile  = wrap_k && wrap_n && wrap_m;
   // Only this tile's beats can be in flight during DRAIN, so an empty tail marks the final capture.
   assign drain_exit = (state == S_DRAIN) && dl_valid[ARRAY_LAT-1] && (dl_valid[ARRAY_LAT-2:0] == '0);
   assign adv_k      = drain_exit && !last_tile;
   assign adv_n      = adv_k && wrap_k;
   assign adv_m      = adv_n && wrap_n;

   sys_array_tile_cnt #(.TILE(TILE_W), .DIM_WIDTH(DIM_WIDTH), .LEN_WIDTH(M_LEN_W)) u_cnt_m (
      .clk(clk), .reset_n(reset_n), .en(en), .load(accept), .dim_in(dim_m),
      .adv_in(adv_m), .origin(m0), .len(m_len), .wrap(wrap_m)
   );

   sys_array_tile_cnt #(.TILE(TILE_L), .DIM_WIDTH(DIM_WIDTH), .LEN_WIDTH(K_LEN_W)) u_cnt_k (
      .clk(clk), .reset_n(reset_n), .en(en), .load(accept), .dim_in(dim_k),
      .adv_in(adv_k), .origin(k0), .len(k_len), .wrap(wrap_k)
   );

   sys_array_tile_cnt #(.TILE(TILE_A_L), .DIM_WIDTH(DIM_WIDTH), .LEN_WIDTH(N_LEN_W)) u_cnt_n (
      .clk(clk), .reset_n(reset_n), .en(en), .load(accept), .dim_in(dim_n),
      .adv_in(adv_n), .origin(n0), .len(n_len), .wrap(wrap_n)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         col_cnt <= '0;
      end else if (en) begin
         case (state)
            S_IDLE:   if (start) state <= any_zero ? S_DONE : S_FETCH;
            S_FETCH:  if (bus.fetch_ack) state <= S_LOAD;
            S_LOAD: begin
               state   <= S_STREAM;
               col_cnt <= '0;
            end
            S_STREAM: begin
               if (last_col) begin
                  state   <= S_DRAIN;
                  col_cnt <= '0;
               end else begin
                  col_cnt <= col_cnt + IDX_W'(1);
               end
            end
            S_DRAIN:  if (drain_exit) state <= last_tile ? S_DONE : S_FETCH;
            S_DONE:   state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Stand-in for the array pipeline: each stream beat reappears as a capture beat ARRAY_LAT cycles on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_valid <= '0;
         for (int i = 0; i < ARRAY_LAT; i++) dl_idx[i] <= '0;
      end else if (en) begin
         dl_valid  <= {dl_valid[ARRAY_LAT-2:0], bus.b_col_valid};
         dl_idx[0] <= bus.b_col_valid ? col_cnt : '0;
         for (int i = 1; i < ARRAY_LAT; i++) dl_idx[i] <= dl_idx[i-1];
      end
   end

   assign busy            = in_tile;
   assign done            = (state == S_DONE);
   assign bus.fetch_req   = (state == S_FETCH);
   assign bus.w_load      = (state == S_LOAD);
   assign bus.b_col_valid = (state == S_STREAM);
   assign bus.b_col_idx   = col_cnt;
   assign bus.o_valid     = dl_valid[ARRAY_LAT-1];
   assign bus.o_col_idx   = dl_idx[ARRAY_LAT-1];
   assign bus.tile_m0     = m0;
   assign bus.tile_k0     = k0;
   assign bus.tile_n0     = n0;
   assign bus.tile_m_len  = m_len;
   assign bus.tile_k_len  = k_len;
   assign bus.tile_n_len  = n_len;
   assign bus.acc_first   = in_tile && (k0 == '0);
   assign bus.acc_last    = in_tile && wrap_k;

`ifdef SYS_ARRAY_TILER_PERF_EN
   // Saturating counters, cleared by each accepted start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else if (en) begin
         if (accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
         end else begin
            if (in_tile && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if ((state == S_FETCH) && !bus.fetch_ack && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule
